// File: rtl/pit_pkg.sv
// pit_pkg: shared state encoding and constants for the PIT channel counter control.
package pit_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } pit_state_e;
    localparam int unsigned PIT_COUNT_SIZE = 16;
    localparam int unsigned PIT_TERM_CNT   = 1;
endpackage

// File: rtl/pit_count_ctrl.sv
// pit_count_ctrl: PIT channel main counter; modulus register, load/run/stop FSM,
// prescaler enable, terminal-count flag and interrupt in periodic or one-shot mode.
module pit_count_ctrl
    import pit_pkg::*;
#(
    parameter int unsigned COUNT_SIZE = PIT_COUNT_SIZE
) (
    input  logic                  bus_clk,
    input  logic                  sync_reset,
    input  logic                  cnt_en,
    input  logic                  one_shot,
    input  logic                  mod_wr,
    input  logic [COUNT_SIZE-1:0] mod_data,
    input  logic                  prescale_tick,
    input  logic                  flag_clr,
    input  logic                  irq_en,
    output logic                  cnt_sync_o,
    output logic [COUNT_SIZE-1:0] cnt_value,
    output logic                  rollover_o,
    output logic                  pit_flag,
    output logic                  pit_irq_o,
    output logic                  busy
);
    localparam logic [COUNT_SIZE-1:0] TERM = COUNT_SIZE'(PIT_TERM_CNT);
    localparam logic [COUNT_SIZE-1:0] ONE  = COUNT_SIZE'(1);

    pit_state_e            state_q, state_d;
    logic [COUNT_SIZE-1:0] mod_q, mod_d, cnt_q, cnt_d;
    logic                  flag_q, flag_d, ro_q, sync_q, tc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mod_d   = mod_wr ? mod_data : mod_q;
        tc      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = cnt_en ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                cnt_d   = cnt_en ? mod_q : '0;
                state_d = cnt_en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                // reload reads mod_q, so a same-edge mod_wr only affects the next period
                tc = prescale_tick && (cnt_q == TERM);
                if (prescale_tick)
                    cnt_d = tc ? (one_shot ? '0 : mod_q) : cnt_q - ONE;
                if (tc && one_shot)
                    state_d = ST_DONE;
                if (!cnt_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = cnt_en ? ST_DONE : ST_IDLE;
            end
        endcase
        flag_d = tc | (flag_q & ~flag_clr);
    end

    always_ff @(posedge bus_clk) begin
        if (sync_reset) begin
            state_q <= ST_IDLE;
            mod_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            ro_q    <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            ro_q    <= tc;
            sync_q  <= (state_d == ST_RUN);
        end
    end

    assign cnt_sync_o = sync_q;
    assign cnt_value  = cnt_q;
    assign rollover_o = ro_q;
    assign pit_flag   = flag_q;
    assign pit_irq_o  = flag_q & irq_en;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
endmodule

// File: tb/tb_pit_count_ctrl.sv
// tb_pit_count_ctrl: vector table plus hand sequences, expected outputs queued per step.
module tb_pit_count_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0, en = 1'b0, os = 1'b0, wr = 1'b0, tick = 1'b0, clr = 1'b0, ie = 1'b0;
    logic [CW-1:0] data = '0;
    logic          sync_o, ro_o, flag_o, irq_o, busy_o;
    logic [CW-1:0] cnt_o;

    int checks = 0;
    int passed = 0;

    logic [8:0] exp_q[$];
    string      name_q[$];

    typedef struct {
        string         nm;
        logic          rst, en, os, wr;
        logic [CW-1:0] data;
        logic          tick, clr, ie, sync;
        logic [CW-1:0] cnt;
        logic          ro, flag, irq, busy;
    } vec_t;

    vec_t tbl[$];

    pit_count_ctrl #(.COUNT_SIZE(CW)) dut (
        .bus_clk(clk), .sync_reset(rst), .cnt_en(en), .one_shot(os),
        .mod_wr(wr), .mod_data(data), .prescale_tick(tick), .flag_clr(clr),
        .irq_en(ie), .cnt_sync_o(sync_o), .cnt_value(cnt_o), .rollover_o(ro_o),
        .pit_flag(flag_o), .pit_irq_o(irq_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic r, e, o, w, input logic [CW-1:0] d,
                                input logic t, c, i, s, input logic [CW-1:0] n,
                                input logic ro, f, q, b);
        vec_t v;
        v.nm = nm; v.rst = r; v.en = e; v.os = o; v.wr = w; v.data = d;
        v.tick = t; v.clr = c; v.ie = i; v.sync = s; v.cnt = n;
        v.ro = ro; v.flag = f; v.irq = q; v.busy = b;
        return v;
    endfunction

    task automatic step(input string nm, input logic r, e, o, w, input logic [CW-1:0] d,
                        input logic t, c, i, s, input logic [CW-1:0] n,
                        input logic ro, f, q, b);
        logic [8:0] got, want;
        string      cur;
        @(negedge clk);
        rst = r; en = e; os = o; wr = w; data = d; tick = t; clr = c; ie = i;
        exp_q.push_back({s, n, ro, f, q, b});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        got  = {sync_o, cnt_o, ro_o, flag_o, irq_o, busy_o};
        want = exp_q.pop_front();
        cur  = name_q.pop_front();
        checks++;
        if (got !== want)
            $display("FAIL %s: got {sync,cnt,ro,flag,irq,busy}=%b required %b", cur, got, want);
        else
            passed++;
    endtask

    initial begin
        // name rst en os wr data tick clr ie | sync cnt ro flag irq busy
        tbl.push_back(mk("reset",       1,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("wr_mod4",     0,0,0,1,4, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("load",        0,1,0,0,0, 0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk("run_4",       0,1,0,0,0, 1,0,0, 1,4,0,0,0,1));
        tbl.push_back(mk("dec_3",       0,1,0,0,0, 1,0,0, 1,3,0,0,0,1));
        tbl.push_back(mk("dec_2",       0,1,0,0,0, 1,0,0, 1,2,0,0,0,1));
        tbl.push_back(mk("dec_1",       0,1,0,0,0, 1,0,0, 1,1,0,0,0,1));
        tbl.push_back(mk("tc_noirq",    0,1,0,0,0, 1,0,0, 1,4,1,1,0,1));
        tbl.push_back(mk("irq_on_3",    0,1,0,0,0, 1,0,1, 1,3,0,1,1,1));
        tbl.push_back(mk("per_2",       0,1,0,0,0, 1,0,1, 1,2,0,1,1,1));
        tbl.push_back(mk("per_1",       0,1,0,0,0, 1,0,1, 1,1,0,1,1,1));
        tbl.push_back(mk("set_beats_clr",0,1,0,0,0,1,1,1, 1,4,1,1,1,1));
        tbl.push_back(mk("clr_after",   0,1,0,0,0, 1,1,1, 1,3,0,0,0,1));
        tbl.push_back(mk("per2_2",      0,1,0,0,0, 1,0,1, 1,2,0,0,0,1));
        tbl.push_back(mk("per2_1",      0,1,0,0,0, 1,0,1, 1,1,0,0,0,1));
        tbl.push_back(mk("tc_third",    0,1,0,0,0, 1,0,1, 1,4,1,1,1,1));
        tbl.push_back(mk("en_drop",     0,0,0,0,0, 0,0,1, 0,0,0,1,1,0));
        foreach (tbl[i])
            step(tbl[i].nm, tbl[i].rst, tbl[i].en, tbl[i].os, tbl[i].wr, tbl[i].data,
                 tbl[i].tick, tbl[i].clr, tbl[i].ie, tbl[i].sync, tbl[i].cnt,
                 tbl[i].ro, tbl[i].flag, tbl[i].irq, tbl[i].busy);

        // one-shot, modulus 3, tick every other cycle
        step("os_clr",      0,0,0,0,0, 0,1,0, 0,0,0,0,0,0);
        step("os_wr3",      0,0,0,1,3, 0,0,0, 0,0,0,0,0,0);
        step("os_load",     0,1,1,0,0, 0,0,0, 0,0,0,0,0,1);
        step("os_run3",     0,1,1,0,0, 0,0,0, 1,3,0,0,0,1);
        step("os_2",        0,1,1,0,0, 1,0,0, 1,2,0,0,0,1);
        step("os_hold2",    0,1,1,0,0, 0,0,0, 1,2,0,0,0,1);
        step("os_1",        0,1,1,0,0, 1,0,0, 1,1,0,0,0,1);
        step("os_hold1",    0,1,1,0,0, 0,0,0, 1,1,0,0,0,1);
        step("os_tc_done",  0,1,1,0,0, 1,0,0, 0,0,1,1,0,0);
        step("done_ign1",   0,1,1,0,0, 1,0,0, 0,0,0,1,0,0);
        step("done_ign2",   0,1,1,0,0, 1,0,0, 0,0,0,1,0,0);
        step("done_idle",   0,0,1,0,0, 0,0,0, 0,0,0,1,0,0);
        step("re_load",     0,1,1,0,0, 0,0,0, 0,0,0,1,0,1);
        step("re_run3",     0,1,1,0,0, 0,0,0, 1,3,0,1,0,1);

        // modulus 0 wraps: 16 ticks per period
        step("m0_idle",     0,0,0,1,0, 0,1,0, 0,0,0,0,0,0);
        step("m0_load",     0,1,0,0,0, 0,0,0, 0,0,0,0,0,1);
        step("m0_run0",     0,1,0,0,0, 0,0,0, 1,0,0,0,0,1);
        step("m0_wrap15",   0,1,0,0,0, 1,0,0, 1,15,0,0,0,1);
        for (int k = 2; k <= 15; k++)
            step("m0_dec",  0,1,0,0,0, 1,0,0, 1,CW'(16-k),0,0,0,1);
        step("m0_tc16",     0,1,0,0,0, 1,0,0, 1,0,1,1,0,1);

        // modulus write mid-period, and on the reload edge
        step("mw_idle5",    0,0,0,1,5, 0,1,0, 0,0,0,0,0,0);
        step("mw_load",     0,1,0,0,0, 0,0,0, 0,0,0,0,0,1);
        step("mw_run5",     0,1,0,0,0, 0,0,0, 1,5,0,0,0,1);
        step("mw_wr7",      0,1,0,1,7, 1,0,0, 1,4,0,0,0,1);
        for (int k = 3; k >= 1; k--)
            step("mw_dec",  0,1,0,0,0, 1,0,0, 1,CW'(k),0,0,0,1);
        step("mw_reload7",  0,1,0,0,0, 1,0,0, 1,7,1,1,0,1);
        for (int k = 6; k >= 1; k--)
            step("mw_dec7", 0,1,0,0,0, 1,0,0, 1,CW'(k),0,1,0,1);
        step("mw_wr9_old7", 0,1,0,1,9, 1,0,0, 1,7,1,1,0,1);
        for (int k = 6; k >= 1; k--)
            step("mw_dec7b",0,1,0,0,0, 1,0,0, 1,CW'(k),0,1,0,1);
        step("mw_reload9",  0,1,0,0,0, 1,0,0, 1,9,1,1,0,1);

        // synchronous reset mid-RUN at count 2
        for (int k = 8; k >= 2; k--)
            step("rs_dec",  0,1,0,0,0, 1,0,1, 1,CW'(k),0,1,1,1);
        step("rs_reset",    1,1,0,0,0, 1,0,1, 0,0,0,0,0,0);
        step("rs_load",     0,1,0,0,0, 0,0,1, 0,0,0,0,0,1);
        step("rs_mod0",     0,1,0,0,0, 0,0,1, 1,0,0,0,0,1);

        // cnt_en drop on the terminal-count edge still reports it
        step("ed_idle",     0,0,0,1,2, 0,0,1, 0,0,0,0,0,0);
        step("ed_load",     0,1,0,0,0, 0,0,1, 0,0,0,0,0,1);
        step("ed_run2",     0,1,0,0,0, 0,0,1, 1,2,0,0,0,1);
        step("ed_1",        0,1,0,0,0, 1,0,1, 1,1,0,0,0,1);
        step("ed_drop_tc",  0,0,0,0,0, 1,0,1, 0,0,1,1,1,0);
        step("ed_idle_hold",0,0,0,0,0, 1,0,1, 0,0,0,1,1,0);
        step("ed_irq_mask", 0,0,0,0,0, 0,0,0, 0,0,0,1,0,0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
